// File: rtl/axil_arb_pkg.sv
// Shared types and helpers for the AXI-Lite request arbiter.
// The AXIL_ARB_TIMEOUT_EN build adds the DRAIN recovery path.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_RESP,
    RD_ADDR,
    RD_RESP,
    DRAIN
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int         MAX_M       = 8;

  // Returns {found, index}: first requester at or after ptr, modulo n.
  function automatic logic [3:0] rr_pick(
    input logic [MAX_M-1:0] req,
    input logic [2:0]       ptr,
    input int               n
  );
    logic [3:0] r;
    int         j;
    r = '0;
    for (int i = 0; i < MAX_M; i++) begin
      j = (int'(ptr) + i) % n;
      if (i < n && !r[3] && req[j]) r = {1'b1, 3'(j)};
    end
    return r;
  endfunction

endpackage

// File: rtl/axil_req_arb_picker.sv
// Rotating-priority picker: one-hot grant plus its index.
// Purely combinational; the top registers the result.
module axil_rr_picker
  import axil_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IW    = 1
) (
  input  logic [NUM_M-1:0] req,
  input  logic [IW-1:0]    rr_ptr,
  output logic [NUM_M-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             found
);

  logic [MAX_M-1:0] req_x;
  logic [2:0]       ptr_x;
  logic [3:0]       pick;

  always_comb begin
    req_x            = '0;
    req_x[NUM_M-1:0] = req;
    ptr_x            = '0;
    ptr_x[IW-1:0]    = rr_ptr;
    pick             = rr_pick(req_x, ptr_x, NUM_M);
    found            = pick[3];
    idx              = IW'(pick[2:0]);
    gnt              = '0;
    if (found) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/axil_req_arb.sv
// Round-robin arbiter sharing one AXI-Lite slave among NUM_M masters.
// Define AXIL_ARB_TIMEOUT_EN for the response watchdog and DRAIN state.
module axil_req_arb
  import axil_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      axi_clk,
  input  logic                      axi_reset,
  input  logic [NUM_M-1:0]          m_awvalid,
  output logic [NUM_M-1:0]          m_awready,
  input  logic [NUM_M*ADDR_W-1:0]   m_awaddr,
  input  logic [NUM_M-1:0]          m_wvalid,
  output logic [NUM_M-1:0]          m_wready,
  input  logic [NUM_M*DATA_W-1:0]   m_wdata,
  input  logic [NUM_M*DATA_W/8-1:0] m_wstrb,
  output logic [NUM_M-1:0]          m_bvalid,
  input  logic [NUM_M-1:0]          m_bready,
  output logic [NUM_M*2-1:0]        m_bresp,
  input  logic [NUM_M-1:0]          m_arvalid,
  output logic [NUM_M-1:0]          m_arready,
  input  logic [NUM_M*ADDR_W-1:0]   m_araddr,
  output logic [NUM_M-1:0]          m_rvalid,
  input  logic [NUM_M-1:0]          m_rready,
  output logic [NUM_M*DATA_W-1:0]   m_rdata,
  output logic [NUM_M*2-1:0]        m_rresp,
  output logic                      s_awvalid,
  input  logic                      s_awready,
  output logic [ADDR_W-1:0]         s_awaddr,
  output logic                      s_wvalid,
  input  logic                      s_wready,
  output logic [DATA_W-1:0]         s_wdata,
  output logic [DATA_W/8-1:0]       s_wstrb,
  input  logic                      s_bvalid,
  output logic                      s_bready,
  input  logic [1:0]                s_bresp,
  output logic                      s_arvalid,
  input  logic                      s_arready,
  output logic [ADDR_W-1:0]         s_araddr,
  input  logic                      s_rvalid,
  output logic                      s_rready,
  input  logic [DATA_W-1:0]         s_rdata,
  input  logic [1:0]                s_rresp
);

  localparam int SW = DATA_W / 8;
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  state_t          state, state_d;
  logic [IW-1:0]   grant, rr_ptr, nxt_ptr, pick_idx;
  logic [NUM_M-1:0] req_wr, req_any, pick_gnt;
  logic            pick_found, pick_wr;
  logic            aw_done, w_done, aw_hs, w_hs;
  logic            to_hit;
  int unsigned     g;

  assign req_wr  = m_awvalid & m_wvalid;
  assign req_any = req_wr | m_arvalid;
  assign pick_wr = |(pick_gnt & req_wr);
  assign g       = 32'(grant);
  assign nxt_ptr = (g == NUM_M - 1) ? '0 : grant + 1'b1;

  axil_rr_picker #(
    .NUM_M (NUM_M),
    .IW    (IW)
  ) u_pick (
    .req    (req_any),
    .rr_ptr (rr_ptr),
    .gnt    (pick_gnt),
    .idx    (pick_idx),
    .found  (pick_found)
  );

`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;

  assign to_hit = (cnt == CW'(TIMEOUT));

  // Cleared on every state change; saturates at the limit.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      cnt <= '0;
    end else if (state_d != state) begin
      cnt <= '0;
    end else if ((state == WR_RESP || state == RD_RESP ||
                  state == DRAIN) && !to_hit) begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;
    m_awready = '0;
    m_wready  = '0;
    m_arready = '0;
    m_bvalid  = '0;
    m_bresp   = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    m_rresp   = '0;
    s_awvalid = 1'b0;
    s_awaddr  = '0;
    s_wvalid  = 1'b0;
    s_wdata   = '0;
    s_wstrb   = '0;
    s_bready  = 1'b0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_rready  = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_found) state_d = pick_wr ? WR_ADDR : RD_ADDR;
      end
      WR_ADDR: begin
        s_awvalid        = m_awvalid[grant] & ~aw_done;
        s_awaddr         = m_awaddr[g*ADDR_W +: ADDR_W];
        s_wvalid         = m_wvalid[grant] & ~w_done;
        s_wdata          = m_wdata[g*DATA_W +: DATA_W];
        s_wstrb          = m_wstrb[g*SW +: SW];
        m_awready[grant] = s_awready & ~aw_done;
        m_wready[grant]  = s_wready & ~w_done;
        aw_hs            = s_awvalid & s_awready;
        w_hs             = s_wvalid & s_wready;
        if ((aw_done | aw_hs) & (w_done | w_hs)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (to_hit) begin
          m_bvalid[grant]  = 1'b1;
          m_bresp[g*2 +: 2] = RESP_SLVERR;
          if (m_bready[grant]) state_d = DRAIN;
        end else begin
          s_bready          = m_bready[grant];
          m_bvalid[grant]   = s_bvalid;
          m_bresp[g*2 +: 2] = s_bresp;
          if (s_bvalid & m_bready[grant]) state_d = IDLE;
        end
      end
      RD_ADDR: begin
        s_arvalid        = m_arvalid[grant];
        s_araddr         = m_araddr[g*ADDR_W +: ADDR_W];
        m_arready[grant] = s_arready;
        if (m_arvalid[grant] & s_arready) state_d = RD_RESP;
      end
      RD_RESP: begin
        if (to_hit) begin
          m_rvalid[grant]   = 1'b1;
          m_rresp[g*2 +: 2] = RESP_SLVERR;
          if (m_rready[grant]) state_d = DRAIN;
        end else begin
          s_rready                   = m_rready[grant];
          m_rvalid[grant]            = s_rvalid;
          m_rdata[g*DATA_W +: DATA_W] = s_rdata;
          m_rresp[g*2 +: 2]          = s_rresp;
          if (s_rvalid & m_rready[grant]) state_d = IDLE;
        end
      end
`ifdef AXIL_ARB_TIMEOUT_EN
      DRAIN: begin
        // Swallow the late slave response, or give up after another limit.
        s_bready = 1'b1;
        s_rready = 1'b1;
        if (s_bvalid | s_rvalid | to_hit) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state <= IDLE;
    else           state <= state_d;
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      grant   <= '0;
      rr_ptr  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) begin
        grant   <= pick_idx;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if (state != IDLE && state_d == IDLE) rr_ptr <= nxt_ptr;
    end
  end

endmodule

// File: tb/tb_axil_req_arb.sv
// Scoreboard bench for axil_req_arb with a scripted slave model.
// Build with AXIL_ARB_TIMEOUT_EN to also exercise the watchdog.
module tb_axil_req_arb;

  localparam int NM = 2;
  localparam int AW = 15;
  localparam int DW = 32;
`ifdef AXIL_ARB_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic              axi_clk, axi_reset;
  logic [NM-1:0]     m_awvalid, m_awready, m_wvalid, m_wready;
  logic [NM*AW-1:0]  m_awaddr, m_araddr;
  logic [NM*DW-1:0]  m_wdata, m_rdata;
  logic [NM*4-1:0]   m_wstrb;
  logic [NM-1:0]     m_bvalid, m_bready, m_arvalid, m_arready;
  logic [NM-1:0]     m_rvalid, m_rready;
  logic [NM*2-1:0]   m_bresp, m_rresp;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic              s_bvalid, s_bready, s_arvalid, s_arready;
  logic              s_rvalid, s_rready;
  logic [AW-1:0]     s_awaddr, s_araddr;
  logic [DW-1:0]     s_wdata, s_rdata;
  logic [3:0]        s_wstrb;
  logic [1:0]        s_bresp, s_rresp;

  axil_req_arb #(
    .NUM_M(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_bresp(m_bresp), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_araddr(m_araddr), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_rdata(m_rdata), .m_rresp(m_rresp),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_bresp(s_bresp), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_araddr(s_araddr), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_rdata(s_rdata), .s_rresp(s_rresp)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    s;
  } slv_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [1:0]    r;
  } rsp_t;

  slv_t exp_slv[$];
  rsp_t exp_b[NM][$];
  rsp_t exp_r[NM][$];

  int applied = 0;
  int miscmp  = 0;
  int ar_dly = 0, aw_dly = 0, w_dly = 0, rsp_dly = 0, late_dly = 0;
  bit r_mute = 0;

  initial begin
    axi_clk = 0;
    forever #5 axi_clk = ~axi_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    applied++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(string nm);
    applied++;
    miscmp++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // ---------------- slave model ----------------
  task automatic slv_check(logic wr, logic [AW-1:0] a,
                           logic [DW-1:0] d, logic [3:0] s);
    slv_t e;
    if (exp_slv.size() == 0) begin
      bad("slv_unexpected");
      return;
    end
    e = exp_slv.pop_front();
    chk("slv_op", 32'(wr), 32'(e.wr));
    chk("slv_addr", 32'(a), 32'(e.a));
    if (wr) begin
      chk("slv_wdata", d, e.d);
      chk("slv_wstrb", 32'(s), 32'(e.s));
    end
  endtask

  task automatic slv_read();
    logic [AW-1:0] a;
    int k;
    a = s_araddr;
    @(posedge axi_clk); #1;
    repeat (ar_dly) begin @(posedge axi_clk); #1; end
    s_arready = 1;
    @(posedge axi_clk); #1;
    s_arready = 0;
    slv_check(1'b0, a, '0, '0);
    repeat (r_mute ? late_dly : rsp_dly) begin @(posedge axi_clk); #1; end
    if (axi_reset) return;
    s_rvalid = 1;
    s_rdata  = 32'hDEAD_0000 | 32'(a);
    s_rresp  = 2'b00;
    k = 0;
    do begin @(negedge axi_clk); k++; end
    while (!s_rready && !axi_reset && k < 64);
    if (k >= 64) bad("slv_r_timeout");
    @(posedge axi_clk); #1;
    s_rvalid = 0;
  endtask

  task automatic slv_write();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    s;
    int k;
    @(posedge axi_clk); #1;
    fork
      begin
        repeat (aw_dly) begin @(posedge axi_clk); #1; end
        s_awready = 1;
        @(negedge axi_clk);
        a = s_awaddr;
        @(posedge axi_clk); #1;
        s_awready = 0;
      end
      begin
        repeat (w_dly) begin @(posedge axi_clk); #1; end
        s_wready = 1;
        @(negedge axi_clk);
        d = s_wdata;
        s = s_wstrb;
        @(posedge axi_clk); #1;
        s_wready = 0;
      end
    join
    slv_check(1'b1, a, d, s);
    repeat (rsp_dly) begin @(posedge axi_clk); #1; end
    s_bvalid = 1;
    s_bresp  = (a == 15'h7FFC) ? 2'b10 : 2'b00;
    k = 0;
    do begin @(negedge axi_clk); k++; end
    while (!s_bready && !axi_reset && k < 64);
    if (k >= 64) bad("slv_b_timeout");
    @(posedge axi_clk); #1;
    s_bvalid = 0;
  endtask

  initial begin : slave
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
    forever begin
      @(negedge axi_clk);
      if (axi_reset) continue;
      if (s_arvalid) slv_read();
      else if (s_awvalid || s_wvalid) slv_write();
    end
  end

  // ---------------- response monitor ----------------
  always @(negedge axi_clk) begin
    rsp_t e;
    for (int i = 0; i < NM; i++) begin
      if (m_bvalid[i] && !m_bready[i]) bad("b_unsolicited");
      if (m_rvalid[i] && !m_rready[i]) bad("r_unsolicited");
      if (m_bvalid[i] && m_bready[i]) begin
        if (exp_b[i].size() == 0) bad("b_unexpected");
        else begin
          e = exp_b[i].pop_front();
          chk("bresp", 32'(m_bresp[i*2 +: 2]), 32'(e.r));
        end
      end
      if (m_rvalid[i] && m_rready[i]) begin
        if (exp_r[i].size() == 0) bad("r_unexpected");
        else begin
          e = exp_r[i].pop_front();
          chk("rdata", m_rdata[i*DW +: DW], e.d);
          chk("rresp", 32'(m_rresp[i*2 +: 2]), 32'(e.r));
        end
      end
    end
    if (!$onehot0(m_awready | m_wready | m_arready | m_bvalid | m_rvalid))
      bad("multi_grant");
  end

  // ---------------- master drivers ----------------
  task automatic m_write(int m, logic [AW-1:0] a, logic [DW-1:0] d,
                         logic [3:0] s, logic [1:0] er);
    bit awp, wp, ah, wh, bd;
    int k;
    exp_b[m].push_back('{d: '0, r: er});
    m_awaddr[m*AW +: AW] = a;
    m_wdata[m*DW +: DW]  = d;
    m_wstrb[m*4 +: 4]    = s;
    m_awvalid[m] = 1;
    m_wvalid[m]  = 1;
    m_bready[m]  = 1;
    awp = 1; wp = 1; k = 0;
    while ((awp || wp) && k < 200) begin
      @(negedge axi_clk);
      ah = awp && m_awready[m];
      wh = wp && m_wready[m];
      @(posedge axi_clk); #1;
      if (ah) begin m_awvalid[m] = 0; awp = 0; end
      if (wh) begin m_wvalid[m] = 0; wp = 0; end
      k++;
    end
    if (awp || wp) bad("m_aw_w_timeout");
    bd = 0; k = 0;
    while (!bd && k < 200) begin
      @(negedge axi_clk);
      bd = m_bvalid[m];
      @(posedge axi_clk); #1;
      k++;
    end
    m_bready[m] = 0;
    if (!bd) bad("m_b_timeout");
  endtask

  task automatic m_read(int m, logic [AW-1:0] a, logic [DW-1:0] d,
                        logic [1:0] er);
    bit ah, rd;
    int k;
    exp_r[m].push_back('{d: d, r: er});
    m_araddr[m*AW +: AW] = a;
    m_arvalid[m] = 1;
    m_rready[m]  = 1;
    ah = 0; k = 0;
    while (!ah && k < 200) begin
      @(negedge axi_clk);
      ah = m_arready[m];
      @(posedge axi_clk); #1;
      k++;
    end
    m_arvalid[m] = 0;
    if (!ah) bad("m_ar_timeout");
    rd = 0; k = 0;
    while (!rd && k < 200) begin
      @(negedge axi_clk);
      rd = m_rvalid[m];
      @(posedge axi_clk); #1;
      k++;
    end
    m_rready[m] = 0;
    if (!rd) bad("m_r_timeout");
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int k, n;
    axi_reset = 1;
    m_awvalid = '0; m_wvalid = '0; m_bready = '0;
    m_arvalid = '0; m_rready = '0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_wstrb = '0;
    repeat (3) @(posedge axi_clk);
    @(negedge axi_clk);
    chk("rst_s_awvalid", 32'(s_awvalid), 0);
    chk("rst_s_arvalid", 32'(s_arvalid), 0);
    chk("rst_m_ready", 32'({m_awready, m_wready, m_arready}), 0);
    chk("rst_m_rdata", m_rdata[DW-1:0], 0);
    @(posedge axi_clk); #1;
    axi_reset = 0;

    // single write from master 0, 1-cycle grant latency
    exp_slv.push_back('{wr: 1, a: 15'h0010, d: 32'hA5A5_A5A5, s: 4'hF});
    fork
      m_write(0, 15'h0010, 32'hA5A5_A5A5, 4'hF, 2'b00);
      begin
        @(negedge axi_clk);
        chk("lat_idle_awvalid", 32'(s_awvalid), 0);
        @(negedge axi_clk);
        chk("lat_grant_awvalid", 32'(s_awvalid), 1);
        chk("lat_grant_awaddr", 32'(s_awaddr), 32'h0010);
        chk("lat_grant_wdata", s_wdata, 32'hA5A5_A5A5);
      end
    join

    // simultaneous reads right after reset: master 0 first
    @(posedge axi_clk); #1; axi_reset = 1;
    @(posedge axi_clk); #1; axi_reset = 0;
    exp_slv.push_back('{wr: 0, a: 15'h0020, d: '0, s: '0});
    exp_slv.push_back('{wr: 0, a: 15'h0030, d: '0, s: '0});
    fork
      m_read(0, 15'h0020, 32'hDEAD_0020, 2'b00);
      m_read(1, 15'h0030, 32'hDEAD_0030, 2'b00);
    join

    // W completes two cycles before AW, top address returns SLVERR
    w_dly = 0; aw_dly = 2;
    exp_slv.push_back('{wr: 1, a: 15'h7FFC, d: 32'h1234_5678, s: 4'h3});
    m_write(0, 15'h7FFC, 32'h1234_5678, 4'h3, 2'b10);
    aw_dly = 0;

    // master 1 writes vs master 0 reads: grants alternate 1,0,1,0...
    rsp_dly = 1;
    for (int i = 0; i < 4; i++) begin
      exp_slv.push_back('{wr: 1, a: AW'(32'h200 + 4*i),
                          d: 32'h1111_0000 + i, s: 4'hF});
      exp_slv.push_back('{wr: 0, a: AW'(32'h100 + 4*i), d: '0, s: '0});
    end
    fork
      for (int i = 0; i < 4; i++)
        m_write(1, AW'(32'h200 + 4*i), 32'h1111_0000 + i, 4'hF, 2'b00);
      for (int i = 0; i < 4; i++)
        m_read(0, AW'(32'h100 + 4*i), 32'hDEAD_0100 + 4*i, 2'b00);
    join

    // reset during RD_RESP drops the response and clears rr_ptr
    rsp_dly = 6;
    exp_slv.push_back('{wr: 0, a: 15'h0040, d: '0, s: '0});
    m_araddr[AW-1:0] = 15'h0040;
    m_arvalid[0] = 1;
    m_rready[0]  = 1;
    k = 0;
    do begin @(negedge axi_clk); k++; end
    while (!m_arready[0] && k < 50);
    if (k >= 50) bad("rst_ar_timeout");
    @(posedge axi_clk); #1;
    m_arvalid[0] = 0;
    @(negedge axi_clk);
    chk("rd_resp_s_rready", 32'(s_rready), 1);
    @(posedge axi_clk); #1;
    axi_reset = 1;
    @(negedge axi_clk);
    chk("midrst_s_rready", 32'(s_rready), 0);
    chk("midrst_m_rvalid", 32'(m_rvalid), 0);
    chk("midrst_s_arvalid", 32'(s_arvalid), 0);
    repeat (10) @(posedge axi_clk);
    #1;
    axi_reset = 0;
    m_rready[0] = 0;
    rsp_dly = 0;
    exp_slv.push_back('{wr: 0, a: 15'h0050, d: '0, s: '0});
    exp_slv.push_back('{wr: 0, a: 15'h0060, d: '0, s: '0});
    fork
      m_read(0, 15'h0050, 32'hDEAD_0050, 2'b00);
      m_read(1, 15'h0060, 32'hDEAD_0060, 2'b00);
    join

`ifdef AXIL_ARB_TIMEOUT_EN
    // silent slave: SLVERR after TIMEOUT cycles, late R absorbed in DRAIN
    r_mute = 1; late_dly = 11;
    exp_slv.push_back('{wr: 0, a: 15'h0070, d: '0, s: '0});
    fork
      m_read(0, 15'h0070, 32'h0, 2'b10);
      begin
        k = 0;
        do begin @(negedge axi_clk); k++; end
        while (!m_arready[0] && k < 50);
        n = 0;
        do begin @(negedge axi_clk); n++; end
        while (!m_rvalid[0] && n < 40);
        chk("to_latency", 32'(n), 32'(TO + 1));
      end
    join
    r_mute = 0;
    exp_slv.push_back('{wr: 0, a: 15'h0074, d: '0, s: '0});
    m_read(1, 15'h0074, 32'hDEAD_0074, 2'b00);
`endif

    k = 0;
    while ((exp_slv.size() + exp_b[0].size() + exp_b[1].size() +
            exp_r[0].size() + exp_r[1].size()) != 0 && k < 100) begin
      @(negedge axi_clk);
      k++;
    end
    chk("sb_left", 32'(exp_slv.size() + exp_b[0].size() + exp_b[1].size() +
                       exp_r[0].size() + exp_r[1].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscmp);
    $finish;
  end

endmodule
